pwm_fade_ctrl: RTL
==================

Name: pwm_fade_ctrl

Overview:
- Duty-cycle controller for the PWM datapath.
- Takes the 0..100 duty setting from the button-debounce counter as a target, then slews the applied duty toward it one step at a time.
- Generates the PWM waveform and applies duty changes only at PWM period boundaries, so outputs are glitch-free.
- Sits between the debounced button counter and the LED/output pin.

Parameters:
TICK_DIV, 1000, sys_clk cycles per PWM phase tick (>=1)
STEP_PERIODS, 4, complete PWM periods between successive 1-unit duty steps (>=1)
MAX_DUTY, 100, PWM phase steps per period; also the duty ceiling

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = controller running; 0 = output forced off
target_duty  input  7  requested duty 0..MAX_DUTY; values above MAX_DUTY are clamped to MAX_DUTY
pwm_out  output  1  registered PWM waveform
cur_duty  output  7  duty currently applied
busy  output  1  high while ramping (state UP or DOWN)
period_start  output  1  one-cycle pulse at the start of each PWM period

Behaviour:
- Clocking and reset:
  - Single clock, sys_clk.
  - Reset is asynchronous and active-low on sys_rst_n.
  - All state is cleared on reset: prescaler=0, phase=0, period counter=0, state=IDLE, pwm_out=0, cur_duty=0, busy=0, period_start=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while enable=1.
  - tick is asserted in the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - With TICK_DIV=1, tick is asserted every cycle.
- Phase counter:
  - Counts 0..MAX_DUTY-1 and advances only on tick.
  - On a tick with phase==MAX_DUTY-1: phase wraps to 0 and the boundary event fires.
  - period_start is registered: high for exactly the one cycle after the boundary event.
- PWM output:
  - pwm_out is registered: pwm_out <= enable & (phase < cur_duty).
  - One cycle of latency from phase.
  - cur_duty=0 gives a constant low output; cur_duty=MAX_DUTY gives a constant high output.
- FSM states: IDLE, HOLD, UP, DOWN.
  - IDLE: enable=0. Prescaler, phase and period counter are held at 0; cur_duty=0; pwm_out=0. When enable=1, go to HOLD next cycle; counting starts from phase 0.
  - Boundary events only (HOLD/UP/DOWN): target_duty is sampled and clamped to T.
    - T>cur_duty -> UP
    - T<cur_duty -> DOWN
    - T==cur_duty -> HOLD, period counter cleared
  - Direction is re-evaluated at every boundary. Changing the target mid-ramp reverses the ramp at the next boundary; there is no overshoot.
  - Step rule in UP/DOWN:
    - The period counter increments at each boundary.
    - When it reaches STEP_PERIODS-1 at a boundary: cur_duty changes by ±1 at that same boundary, and the counter clears.
    - If the step makes cur_duty==T, the state is HOLD from the next cycle.
  - A boundary in HOLD with T!=cur_duty enters UP/DOWN without stepping. The first step happens STEP_PERIODS boundaries later.
- busy = (state==UP)|(state==DOWN), registered alongside state.
- Arithmetic:
  - cur_duty stays within 0..MAX_DUTY at all times, with no wrap-around.
  - The ramp stops at T, so 0 -1 and MAX_DUTY +1 never occur.
- Disabling (enable falling in any state):
  - Next cycle: state=IDLE, cur_duty=0, pwm_out=0, busy=0.
  - Counters are cleared and no period_start is generated.
  - The abort takes effect immediately, even mid-period or mid-ramp.
- Reset asserted mid-operation behaves as if enable=0 from power-up.
- Latency from a target change to the first duty step: at most MAX_DUTY*TICK_DIV*(STEP_PERIODS+1) cycles.

Optional Feature:
- Macro name: PWM_FADE_BREATHE_EN.
- When defined:
  - Adds input port breathe (1 bit).
  - With breathe=1, the FSM ignores equality with target: on reaching T it goes to DOWN, and on reaching 0 it goes to UP.
  - This gives a continuous triangle fade 0..T.
  - If T==0, the controller stays in HOLD with cur_duty=0.
  - breathe falling resumes normal target-seeking at the next boundary.
- When undefined: no breathe port, and the behaviour is exactly as described above.

Test Plan:
Bench parameters: TICK_DIV=2, STEP_PERIODS=1, MAX_DUTY=100 (one period = 200 cycles).
- Reset, enable=1, target=0 -> pwm_out stays 0 for 3 periods; period_start pulses every 200 cycles; busy=0.
- target=3 from cur=0 -> HOLD→UP at first boundary; cur_duty 1,2,3 at the next three boundaries; busy falls once cur=3; pwm_out high for 6 cycles per period at cur=3.
- target=100 held until cur=100 -> pwm_out constant high for a full period; target=120 -> clamps, cur_duty stays 100, busy=0.
- Ramping up at cur=50, target changed to 40 -> state DOWN at next boundary; cur reaches 40 after 10 further steps with no value above 51.
- enable dropped mid-ramp at phase 37 -> next cycle pwm_out=0, cur_duty=0, busy=0; no period_start until enable is reasserted; restart begins at phase 0.
- (PWM_FADE_BREATHE_EN) breathe=1, target=2 -> cur_duty sequence 1,2,1,0,1,2 on consecutive steps; busy stays 1.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// PWM duty-cycle fader: slews the applied duty toward a clamped target one unit per
// STEP_PERIODS PWM periods, changing duty only at period boundaries. Optional macro: PWM_FADE_BREATHE_EN.
module pwm_fade_ctrl #(
  parameter int TICK_DIV     = 1000,
  parameter int STEP_PERIODS = 4,
  parameter int MAX_DUTY     = 100
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic [6:0] target_duty,
`ifdef PWM_FADE_BREATHE_EN
  input  logic       breathe,
`endif
  output logic       pwm_out,
  output logic [6:0] cur_duty,
  output logic       busy,
  output logic       period_start
);

  typedef enum logic [1:0] {IDLE, HOLD, UP, DOWN} state_t;

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [PSW-1:0] PS_LAST  = PSW'(TICK_DIV - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(STEP_PERIODS - 1);
  localparam logic [6:0]     DUTY_MAX = 7'(MAX_DUTY);
  localparam logic [6:0]     PH_LAST  = 7'(MAX_DUTY - 1);

  logic [PSW-1:0] presc;
  logic [6:0]     phase;
  logic [SCW-1:0] pcnt, pcnt_d;
  state_t         state, state_d, dir;
  logic [6:0]     duty_d;
  logic [6:0]     target_c;
  logic           tick, boundary, breathe_on;

`ifdef PWM_FADE_BREATHE_EN
  assign breathe_on = breathe;
`else
  assign breathe_on = 1'b0;
`endif

  assign tick     = enable && (presc == PS_LAST);
  assign boundary = tick && (phase == PH_LAST);
  assign target_c = (target_duty > DUTY_MAX) ? DUTY_MAX : target_duty;

  // Direction to move from duty c toward target t while in state s. In breathe mode
  // equality is ignored: a rising ramp turns at t and a falling ramp turns at 0.
  function automatic state_t next_dir(state_t s, logic [6:0] c, logic [6:0] t, logic br);
    if (br) begin
      if (t == 7'd0) return (c == 7'd0) ? HOLD : DOWN;
      if (s == DOWN) return (c != 7'd0) ? DOWN : UP;
      return (c < t) ? UP : DOWN;
    end
    if (c < t) return UP;
    if (c > t) return DOWN;
    return HOLD;
  endfunction

  // NOTE: async active-low reset in the sensitivity list, and non-blocking (<=) for every
  // flop so all registers update together from pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc        <= '0;
      phase        <= '0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else if (!enable) begin
      presc        <= '0;
      phase        <= '0;
      period_start <= 1'b0;
      pwm_out      <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + 1'b1;
      if (tick) phase <= (phase == PH_LAST) ? 7'd0 : phase + 7'd1;
      period_start <= boundary;
      pwm_out      <= (phase < cur_duty);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cur_duty <= '0;
      pcnt     <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      cur_duty <= duty_d;
      pcnt     <= pcnt_d;
      busy     <= (state_d == UP) || (state_d == DOWN);
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    duty_d  = cur_duty;
    pcnt_d  = pcnt;
    dir     = HOLD;
    if (!enable) begin
      state_d = IDLE;
      duty_d  = '0;
      pcnt_d  = '0;
    end else if (state == IDLE) begin
      state_d = HOLD;
      pcnt_d  = '0;
    end else if (boundary) begin
      dir    = next_dir(state, cur_duty, target_c, breathe_on);
      pcnt_d = '0;
      if ((state == HOLD) || (dir == HOLD)) begin
        // Starting a ramp never steps on the same boundary.
        state_d = dir;
      end else if (pcnt != SC_LAST) begin
        pcnt_d  = pcnt + 1'b1;
        state_d = dir;
      end else begin
        duty_d  = (dir == UP) ? cur_duty + 7'd1 : cur_duty - 7'd1;
        state_d = next_dir(dir, duty_d, target_c, breathe_on);
      end
    end
  end

  a_duty_range: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    cur_duty <= DUTY_MAX);
  a_busy_state: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    busy == ((state == UP) || (state == DOWN)));
  a_idle_quiet: assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    (state == IDLE) |-> (cur_duty == 7'd0) && !busy);

endmodule
